psram_sched: RTL and testbench

Transaction scheduler in front of the PSRAM OPI core. It arbitrates between two requesters: the register-file config port (mode-register access) and the memory bus port (array access). It serialises them onto the core's single start/done interface and enforces a programmable minimum CE-high gap between consecutive transactions. It owns the core's `cflg`, `wr` and address/data inputs, so the core never sees two requesters at once.

---
 rtl/psram_sched.sv | 161 ++++++++++++++++
 tb/tb_psram_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_sched.sv
// Round-robin scheduler serialising config and memory requests onto the PSRAM core's start/done port.
// All outputs registered; enforces a programmable idle gap after each transaction.
module psram_sched #(
  parameter int CPH_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [CPH_WIDTH-1:0] cph_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_wr_i,
  input  logic [7:0]           cfg_ma_i,
  input  logic [7:0]           cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_done_o,
  output logic [7:0]           cfg_rdata_o,
  input  logic                 mem_req_i,
  input  logic                 mem_wr_i,
  input  logic [23:0]          mem_addr_i,
  input  logic [31:0]          mem_wdata_i,
  output logic                 mem_gnt_o,
  output logic                 mem_done_o,
  output logic [31:0]          mem_rdata_o,
  output logic                 core_start_o,
  output logic                 core_cflg_o,
  output logic                 core_wr_o,
  output logic [23:0]          core_addr_o,
  output logic [31:0]          core_wdata_o,
  input  logic                 core_done_i,
  input  logic [31:0]          core_rdata_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 fav_mem_q, fav_mem_d;
  logic [CPH_WIDTH-1:0] gap_q, gap_d;
  logic                 cfg_gnt_q, cfg_gnt_d;
  logic                 mem_gnt_q, mem_gnt_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 mem_done_q, mem_done_d;
  logic                 start_q, start_d;
  logic                 cflg_q, cflg_d;
  logic                 wr_q, wr_d;
  logic [23:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [7:0]           cfg_rdata_q, cfg_rdata_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;
  logic                 pick_cfg;

  always_comb begin
    state_d     = state_q;
    fav_mem_d   = fav_mem_q;
    gap_d       = gap_q;
    cfg_gnt_d   = 1'b0;
    mem_gnt_d   = 1'b0;
    cfg_done_d  = 1'b0;
    mem_done_d  = 1'b0;
    start_d     = 1'b0;
    cflg_d      = cflg_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cfg_rdata_d = cfg_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // cfg wins unless mem is also asking and it is mem's turn
    pick_cfg    = cfg_req_i && !(mem_req_i && fav_mem_q);

    case (state_q)
      S_IDLE: begin
        if (en_i && (cfg_req_i || mem_req_i)) begin
          cflg_d    = pick_cfg;
          wr_d      = pick_cfg ? cfg_wr_i : mem_wr_i;
          addr_d    = pick_cfg ? {16'd0, cfg_ma_i} : mem_addr_i;
          wdata_d   = pick_cfg ? {24'd0, cfg_wdata_i} : mem_wdata_i;
          cfg_gnt_d = pick_cfg;
          mem_gnt_d = !pick_cfg;
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          if (!wr_q) begin
            if (cflg_q) cfg_rdata_d = core_rdata_i[7:0];
            else        mem_rdata_d = core_rdata_i;
          end
          cfg_done_d = cflg_q;
          mem_done_d = !cflg_q;
          fav_mem_d  = cflg_q;
          gap_d      = cph_i;
          state_d    = (cph_i == '0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - CPH_WIDTH'(1);
        if (gap_q <= CPH_WIDTH'(1)) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fav_mem_q   <= 1'b0;
      gap_q       <= '0;
      cfg_gnt_q   <= 1'b0;
      mem_gnt_q   <= 1'b0;
      cfg_done_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      start_q     <= 1'b0;
      cflg_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cfg_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fav_mem_q   <= fav_mem_d;
      gap_q       <= gap_d;
      cfg_gnt_q   <= cfg_gnt_d;
      mem_gnt_q   <= mem_gnt_d;
      cfg_done_q  <= cfg_done_d;
      mem_done_q  <= mem_done_d;
      start_q     <= start_d;
      cflg_q      <= cflg_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cfg_rdata_q <= cfg_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign cfg_gnt_o    = cfg_gnt_q;
  assign mem_gnt_o    = mem_gnt_q;
  assign cfg_done_o   = cfg_done_q;
  assign mem_done_o   = mem_done_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign core_start_o = start_q;
  assign core_cflg_o  = cflg_q;
  assign core_wr_o    = wr_q;
  assign core_addr_o  = addr_q;
  assign core_wdata_o = wdata_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_psram_sched.sv
// Directed bench for psram_sched: timestamp-based transaction model compared every cycle, plus literal spot checks.
module tb_psram_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  cph_i;
  logic        cfg_req_i, cfg_wr_i;
  logic [7:0]  cfg_ma_i, cfg_wdata_i;
  logic        cfg_gnt_o, cfg_done_o;
  logic [7:0]  cfg_rdata_o;
  logic        mem_req_i, mem_wr_i;
  logic [23:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_gnt_o, mem_done_o;
  logic [31:0] mem_rdata_o;
  logic        core_start_o, core_cflg_o, core_wr_o;
  logic [23:0] core_addr_o;
  logic [31:0] core_wdata_o;
  logic        core_done_i;
  logic [31:0] core_rdata_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  psram_sched #(.CPH_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cph_i(cph_i),
    .cfg_req_i(cfg_req_i), .cfg_wr_i(cfg_wr_i), .cfg_ma_i(cfg_ma_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_gnt_o(cfg_gnt_o), .cfg_done_o(cfg_done_o), .cfg_rdata_o(cfg_rdata_o),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_gnt_o(mem_gnt_o), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .core_start_o(core_start_o), .core_cflg_o(core_cflg_o), .core_wr_o(core_wr_o),
    .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_done_i(core_done_i), .core_rdata_i(core_rdata_i), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model: a transaction occupies the port from its grant until its done; the next
  // grant may be sampled no earlier than done + cph + 1 cycles
  bit          in_txn;
  int          accept_from, free_at;
  bit          fav_mem;
  logic        m_gnt_c, m_gnt_m, m_done_c, m_done_m, m_start, m_busy;
  logic        m_cflg, m_wr;
  logic [23:0] m_addr;
  logic [31:0] m_wdata, m_mrd;
  logic [7:0]  m_crd;

  bit          auto_drop = 1'b1;
  int          resp_lat = 2;
  int          resp_cnt = 0;
  logic [31:0] resp_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic win;
    cyc++;
    m_gnt_c = 1'b0; m_gnt_m = 1'b0; m_done_c = 1'b0; m_done_m = 1'b0; m_start = 1'b0;
    if (rst_i) begin
      in_txn = 1'b0; free_at = 0; fav_mem = 1'b0; accept_from = 0;
      m_cflg = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_crd = '0; m_mrd = '0;
      m_busy = 1'b0;
      return;
    end
    if (in_txn) begin
      if (core_done_i && cyc >= accept_from) begin
        if (m_cflg) m_done_c = 1'b1; else m_done_m = 1'b1;
        if (!m_wr) begin
          if (m_cflg) m_crd = core_rdata_i[7:0];
          else        m_mrd = core_rdata_i;
        end
        fav_mem = m_cflg;
        free_at = cyc + int'(cph_i) + 1;
        in_txn  = 1'b0;
      end
    end else if (cyc >= free_at && en_i && (cfg_req_i || mem_req_i)) begin
      win     = cfg_req_i && !(mem_req_i && fav_mem);
      m_cflg  = win;
      m_wr    = win ? cfg_wr_i : mem_wr_i;
      m_addr  = win ? {16'd0, cfg_ma_i} : mem_addr_i;
      m_wdata = win ? {24'd0, cfg_wdata_i} : mem_wdata_i;
      m_gnt_c = win;
      m_gnt_m = !win;
      m_start = 1'b1;
      in_txn  = 1'b1;
      accept_from = cyc + 2;
    end
    m_busy = in_txn || (cyc + 1 < free_at);
  endtask

  task automatic compare_all();
    chk("cfg_gnt",  32'(cfg_gnt_o),    32'(m_gnt_c));
    chk("mem_gnt",  32'(mem_gnt_o),    32'(m_gnt_m));
    chk("cfg_done", 32'(cfg_done_o),   32'(m_done_c));
    chk("mem_done", 32'(mem_done_o),   32'(m_done_m));
    chk("start",    32'(core_start_o), 32'(m_start));
    chk("busy",     32'(busy_o),       32'(m_busy));
    chk("cflg",     32'(core_cflg_o),  32'(m_cflg));
    chk("wr",       32'(core_wr_o),    32'(m_wr));
    chk("addr",     32'(core_addr_o),  32'(m_addr));
    chk("wdata",    core_wdata_o,      m_wdata);
    chk("cfg_rd",   32'(cfg_rdata_o),  32'(m_crd));
    chk("mem_rd",   mem_rdata_o,       m_mrd);
  endtask

  // one clock: model + compare after the rising edge, then requester/core housekeeping at the falling edge
  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
    @(negedge clk_i);
    core_done_i = 1'b0;
    if (auto_drop) begin
      if (cfg_gnt_o) cfg_req_i = 1'b0;
      if (mem_gnt_o) mem_req_i = 1'b0;
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        core_done_i  = 1'b1;
        core_rdata_i = resp_data;
      end
    end
    if (core_start_o) resp_cnt = resp_lat;
  endtask

  initial begin
    int order[4];
    int ng, n, gapb;
    bit dbl;

    rst_i = 1'b1; en_i = 1'b1; cph_i = 4'd0;
    cfg_req_i = 1'b0; cfg_wr_i = 1'b0; cfg_ma_i = 8'h00; cfg_wdata_i = 8'h00;
    mem_req_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = 24'h0; mem_wdata_i = 32'h0;
    core_done_i = 1'b0; core_rdata_i = 32'h0;

    step();
    step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(core_start_o), 32'd0);
    rst_i = 1'b0;
    step();

    // single cfg write
    cfg_req_i = 1'b1; cfg_wr_i = 1'b1; cfg_ma_i = 8'h04; cfg_wdata_i = 8'hA5;
    step();
    chk("t1_gnt", 32'(cfg_gnt_o), 32'd1);
    chk("t1_cflg", 32'(core_cflg_o), 32'd1);
    chk("t1_wr", 32'(core_wr_o), 32'd1);
    chk("t1_addr", 32'(core_addr_o), 32'h000004);
    chk("t1_wdata", core_wdata_o, 32'h000000A5);
    step();
    step();
    chk("t1_core_done_driven", 32'(core_done_i), 32'd1);
    step();
    chk("t1_cfg_done", 32'(cfg_done_o), 32'd1);
    chk("t1_idle", 32'(busy_o), 32'd0);

    // mem read
    resp_data = 32'hDEADBEEF;
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 24'h123456;
    step();
    chk("t2_gnt", 32'(mem_gnt_o), 32'd1);
    chk("t2_addr", 32'(core_addr_o), 32'h123456);
    step();
    step();
    step();
    chk("t2_done", 32'(mem_done_o), 32'd1);
    chk("t2_rdata", mem_rdata_o, 32'hDEADBEEF);
    chk("t2_cfg_rd", 32'(cfg_rdata_o), 32'h00);

    // both held continuously
    auto_drop = 1'b0; ng = 0; dbl = 1'b0;
    cfg_req_i = 1'b1; cfg_wr_i = 1'b1; mem_req_i = 1'b1; mem_wr_i = 1'b1;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      step();
      if (cfg_gnt_o && mem_gnt_o) dbl = 1'b1;
      if (cfg_gnt_o) begin order[ng] = 0; ng = ng + 1; end
      else if (mem_gnt_o) begin order[ng] = 1; ng = ng + 1; end
    end
    cfg_req_i = 1'b0; mem_req_i = 1'b0; auto_drop = 1'b1;
    chk("t3_count", 32'(ng), 32'd4);
    chk("t3_double", 32'(dbl), 32'd0);
    chk("t3_ord0", 32'(order[0]), 32'd0);
    chk("t3_ord1", 32'(order[1]), 32'd1);
    chk("t3_ord2", 32'(order[2]), 32'd0);
    chk("t3_ord3", 32'(order[3]), 32'd1);
    repeat (6) step();

    // gap of 5 between back-to-back mem writes
    cph_i = 4'd5;
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 24'h000100; mem_wdata_i = 32'h01020304;
    for (int i = 0; i < 20 && !mem_done_o; i++) step();
    chk("t4_done", 32'(mem_done_o), 32'd1);
    mem_req_i = 1'b1; mem_addr_i = 24'h000104;
    n = 0; gapb = busy_o ? 1 : 0;
    for (int i = 0; i < 20 && !core_start_o; i++) begin
      step();
      n = n + 1;
      if (!core_start_o && busy_o) gapb = gapb + 1;
    end
    chk("t4_start_dist", 32'(n), 32'd6);
    chk("t4_gap_cycles", 32'(gapb), 32'd5);
    repeat (12) step();
    cph_i = 4'd0;

    // enable dropped during WAIT, spurious done in IDLE
    resp_data = 32'hCAFEF00D;
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 24'h000010;
    step();
    chk("t5_gnt", 32'(mem_gnt_o), 32'd1);
    en_i = 1'b0;
    cfg_req_i = 1'b1; cfg_wr_i = 1'b0; cfg_ma_i = 8'h22;
    step();
    step();
    step();
    chk("t5_done", 32'(mem_done_o), 32'd1);
    chk("t5_rdata", mem_rdata_o, 32'hCAFEF00D);
    repeat (3) begin
      step();
      chk("t5_no_gnt", 32'(cfg_gnt_o), 32'd0);
    end
    core_done_i = 1'b1; core_rdata_i = 32'hFFFFFFFF;
    step();
    chk("t5_spur_cfg", 32'(cfg_done_o), 32'd0);
    chk("t5_spur_mem", 32'(mem_done_o), 32'd0);
    en_i = 1'b1; resp_data = 32'h11223344;
    step();
    chk("t5_cfg_gnt", 32'(cfg_gnt_o), 32'd1);
    chk("t5_cfg_addr", 32'(core_addr_o), 32'h000022);
    step();
    step();
    step();
    chk("t5_cfg_done", 32'(cfg_done_o), 32'd1);
    chk("t5_cfg_rd", 32'(cfg_rdata_o), 32'h44);
    chk("t5_mem_keep", mem_rdata_o, 32'hCAFEF00D);

    // reset during WAIT
    resp_lat = 6;
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 24'h00ABCD;
    step();
    step();
    cfg_req_i = 1'b1; cfg_wr_i = 1'b1; cfg_ma_i = 8'h07; cfg_wdata_i = 8'h3C;
    mem_req_i = 1'b1;
    rst_i = 1'b1; resp_cnt = 0;
    #1;
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_start", 32'(core_start_o), 32'd0);
    chk("t6_gnt", 32'({cfg_gnt_o, mem_gnt_o}), 32'd0);
    chk("t6_done", 32'({cfg_done_o, mem_done_o}), 32'd0);
    chk("t6_addr", 32'(core_addr_o), 32'd0);
    chk("t6_flags", 32'({core_cflg_o, core_wr_o}), 32'd0);
    chk("t6_wdata", core_wdata_o, 32'd0);
    chk("t6_cfg_rd", 32'(cfg_rdata_o), 32'd0);
    chk("t6_mem_rd", mem_rdata_o, 32'd0);
    step();
    rst_i = 1'b0; resp_lat = 2;
    step();
    chk("t6_cfg_first", 32'(cfg_gnt_o), 32'd1);
    chk("t6_mem_wait", 32'(mem_gnt_o), 32'd0);
    chk("t6_wdata2", core_wdata_o, 32'h0000003C);
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
